pad_input_conditioner: RTL

//  Parametrised conditioner for board-level input pads (keys, wakeup, mode straps) feeding e203_soc_top GPIO inputs.
//  Per channel: input inversion, N-stage synchroniser, run-time debounce, rise/fall pulse generation.

---
 rtl/pad_cond_pkg.sv | 26 ++
 rtl/pad_dbnc_ch.sv | 58 +++++
 rtl/pad_input_conditioner.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pad_cond_pkg.sv
// pad_cond_pkg: shared constants and width helpers for the pad input conditioner.
package pad_cond_pkg;

    // Edge encoding carried in the top bit of every event word.
    localparam logic EVT_RISE = 1'b1;
    localparam logic EVT_FALL = 1'b0;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Event word width: edge bit plus channel index.
    function automatic int evt_w(input int num_ch);
        return 1 + clog2(num_ch);
    endfunction

endpackage

// File: rtl/pad_dbnc_ch.sv
// pad_dbnc_ch: one pad channel - optional inversion, N-stage synchroniser,
// run-time debounce and registered rise/fall pulses.
module pad_dbnc_ch #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DBNC_W      = 16,
    parameter logic INV         = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pad,
    input  logic              en,
    input  logic [DBNC_W-1:0] dbnc_cyc,
    output logic              level,
    output logic              rise,
    output logic              fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic [DBNC_W-1:0]      cnt;
    logic [DBNC_W-1:0]      thresh;

    // Synchroniser chain; inversion happens before the first flop so downstream logic is active-high.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignment so every stage samples its pre-edge input.
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pad ^ INV};
    end

    assign s_sync = sync_q[SYNC_STAGES-1];
    // A zero threshold would never commit; treat it as one cycle.
    assign thresh = (dbnc_cyc == '0) ? DBNC_W'(1) : dbnc_cyc;

    // Debounce: commit the synchronised value after thresh consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!en || (s_sync == level)) begin
                cnt <= '0;
            end else if (cnt + DBNC_W'(1) >= thresh) begin
                // cnt stays below the largest threshold, so the increment cannot wrap.
                level <= s_sync;
                cnt   <= '0;
                rise  <= s_sync;
                fall  <= !s_sync;
            end else begin
                cnt <= cnt + DBNC_W'(1);
            end
        end
    end

endmodule

// File: rtl/pad_input_conditioner.sv
// pad_input_conditioner: per-channel debounce plus a shared edge-event FIFO
// with pending bits, fixed-priority arbitration and a sticky overflow flag.
module pad_input_conditioner
    import pad_cond_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                SYNC_STAGES = 2,
    parameter int                DBNC_W      = 16,
    parameter logic [NUM_CH-1:0] INV_MASK    = '0,
    parameter int                FIFO_DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         pad_i,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic [DBNC_W-1:0]         cfg_dbnc_cyc,
    output logic [NUM_CH-1:0]         level_o,
    output logic [NUM_CH-1:0]         rise_o,
    output logic [NUM_CH-1:0]         fall_o,
    output logic                      evt_valid,
    output logic [evt_w(NUM_CH)-1:0]  evt_data,
    input  logic                      evt_ready,
    output logic                      evt_ovf,
    input  logic                      ovf_clr
);

    localparam int IDX_W     = clog2(NUM_CH);
    localparam int IDX_W_INT = (IDX_W > 0) ? IDX_W : 1;
    localparam int PTR_W     = clog2(FIFO_DEPTH);
    localparam int CNT_W     = clog2(FIFO_DEPTH + 1);

    logic [NUM_CH-1:0]    rise_pend, fall_pend;
    logic [NUM_CH-1:0]    rise_req, fall_req;
    logic [NUM_CH-1:0]    rise_clr, fall_clr;
    logic                 sel_valid;
    logic                 sel_edge;
    logic [IDX_W_INT-1:0] sel_idx;
    logic                 push, pop, full, ovf_set;

    logic                 fifo_edge [FIFO_DEPTH];
    logic [IDX_W_INT-1:0] fifo_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pad_dbnc_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DBNC_W      (DBNC_W),
            .INV         (INV_MASK[i])
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .pad      (pad_i[i]),
            .en       (ch_en[i]),
            .dbnc_cyc (cfg_dbnc_cyc),
            .level    (level_o[i]),
            .rise     (rise_o[i]),
            .fall     (fall_o[i])
        );
    end

    // A fresh pulse is visible to the arbiter in its own cycle, giving one-cycle event latency.
    assign rise_req = rise_pend | rise_o;
    assign fall_req = fall_pend | fall_o;

    // Fixed-priority pick: lowest channel first, rise before fall within a channel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel_valid = 1'b0;
        sel_edge  = EVT_FALL;
        sel_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (fall_req[i]) begin
                sel_valid = 1'b1;
                sel_edge  = EVT_FALL;
                sel_idx   = IDX_W_INT'(i);
            end
            if (rise_req[i]) begin
                sel_valid = 1'b1;
                sel_edge  = EVT_RISE;
                sel_idx   = IDX_W_INT'(i);
            end
        end
    end

    assign evt_valid = (count != '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = evt_valid && evt_ready;
    assign push      = sel_valid && (!full || pop);

    // Decode which pending bit the push consumes this cycle.
    always_comb begin
        rise_clr = '0;
        fall_clr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rise_clr[i] = push && (sel_edge == EVT_RISE) && (sel_idx == IDX_W_INT'(i));
            fall_clr[i] = push && (sel_edge == EVT_FALL) && (sel_idx == IDX_W_INT'(i));
        end
    end

    // An event is lost when a pulse hits an already-pending bit that is not leaving this cycle.
    assign ovf_set = |(rise_pend & rise_o & ~rise_clr) | |(fall_pend & fall_o & ~fall_clr);

    // Pending bits and sticky overflow; a pushed bit re-arms if a new pulse arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_pend <= '0;
            fall_pend <= '0;
            evt_ovf   <= 1'b0;
        end else begin
            rise_pend <= (rise_pend & rise_o) | (rise_req & ~rise_clr);
            fall_pend <= (fall_pend & fall_o) | (fall_req & ~fall_clr);
            if (ovf_set)      evt_ovf <= 1'b1;
            else if (ovf_clr) evt_ovf <= 1'b0;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers and count alone define valid entries.
        if (push) begin
            fifo_edge[wr_ptr] <= sel_edge;
            fifo_idx[wr_ptr]  <= sel_idx;
        end
    end

    // FIFO pointers and occupancy; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Show-ahead head; a single channel carries no index field.
    if (IDX_W == 0) begin : g_data_one
        assign evt_data = fifo_edge[rd_ptr];
    end else begin : g_data_many
        assign evt_data = {fifo_edge[rd_ptr], fifo_idx[rd_ptr]};
    end

endmodule
